// File: rtl/sram_arb2_ctrl_pkg.sv
// Shared types for the two-requester SRAM controller.
// FSM states, requester IDs and default geometry.
package sram_arb2_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  localparam int REQ_LD   = 0;
  localparam int REQ_CORE = 1;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;

endpackage

// File: rtl/sram_arb2_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
// prio_i names the requester that wins a tie.
import sram_arb2_ctrl_pkg::*;

module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  // One-hot grant; lone requester wins, ties go to prio_i
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o[REQ_LD]   = 1'b1;
      2'b10:   gnt_o[REQ_CORE] = 1'b1;
      2'b11:   gnt_o[prio_i]   = 1'b1;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arb2_ctrl.sv
// SRAM controller: zero-fills the macro after reset,
// then serves two requesters round-robin.
import sram_arb2_ctrl_pkg::*;

module sram_arb2_ctrl #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                clear,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                rerr,
  output logic                init_done,
  output logic                sram_CEN,
  output logic                sram_WEN,
  output logic [ADDR_W-1:0]   sram_A,
  output logic [DATA_W-1:0]   sram_D,
  input  logic [DATA_W-1:0]   sram_Q
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              prio_q, prio_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              rerr_q, rerr_d;
  logic              done_q, done_d;

  logic [1:0]        arb_req;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_we;
  logic              in_rng;

  assign arb_req = (state_q == ST_ARB) ? req : 2'b00;

  rr_arb2 u_arb (
    .req_i  (arb_req),
    .prio_i (prio_q),
    .gnt_o  (gnt)
  );

  // Select the granted requester's command fields
  always_comb begin
    sel      = gnt[REQ_CORE];
    sel_addr = sel ? addr[2*ADDR_W-1:ADDR_W]
                   : addr[ADDR_W-1:0];
    sel_data = sel ? wdata[2*DATA_W-1:DATA_W]
                   : wdata[DATA_W-1:0];
    sel_we   = we[sel];
    in_rng   = {1'b0, sel_addr} < DEPTH_X;
  end

  // Next state, SRAM drive and read tracking
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prio_d     = prio_q;
    done_d     = done_q;
    rvalid_d   = 2'b00;
    rerr_d     = 1'b0;
    sram_CEN   = 1'b1;
    sram_WEN   = 1'b1;
    sram_A     = '0;
    sram_D     = '0;
    unique case (state_q)
      ST_INIT: begin
        sram_CEN   = 1'b0;
        sram_WEN   = 1'b0;
        sram_A     = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST) begin
          state_d    = ST_ARB;
          init_cnt_d = '0;
          done_d     = 1'b1;
        end
      end
      ST_ARB: begin
        if (|gnt) begin
          prio_d = ~sel;
          if (in_rng) begin
            sram_CEN = 1'b0;
            sram_WEN = ~sel_we;
            sram_A   = sel_addr;
            sram_D   = sel_data;
          end
          if (!sel_we) begin
            rvalid_d[sel] = 1'b1;
            rerr_d        = ~in_rng;
          end
        end
        if (clear) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
          done_d     = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prio_q     <= 1'b0;
      rvalid_q   <= 2'b00;
      rerr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prio_q     <= prio_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      done_q     <= done_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rerr      = rerr_q;
  assign init_done = done_q;
  assign rdata     = (|rvalid_q && !rerr_q) ? sram_Q
                                            : '0;

endmodule

// File: tb/tb_sram_arb2_ctrl.sv
// Bench for sram_arb2_ctrl with a behavioural sram_w16.
// Directed vector table plus init/reset/clear sequences.
module tb_sram_arb2_ctrl;

  logic         CLK = 1'b0;
  logic         reset;
  logic         clear;
  logic [1:0]   req, we;
  logic [7:0]   addr;
  logic [255:0] wdata;
  logic [1:0]   gnt, rvalid;
  logic [127:0] rdata, sram_D, sram_Q;
  logic         rerr, init_done;
  logic         sram_CEN, sram_WEN;
  logic [3:0]   sram_A;

  int n_chk = 0;
  int n_fail = 0;

  sram_arb2_ctrl dut (
    .CLK(CLK), .reset(reset), .clear(clear),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .rerr(rerr), .init_done(init_done),
    .sram_CEN(sram_CEN), .sram_WEN(sram_WEN),
    .sram_A(sram_A), .sram_D(sram_D), .sram_Q(sram_Q)
  );

  always #5 CLK = ~CLK;

  logic [127:0] mem [16];

  always @(posedge CLK) begin
    if (!sram_CEN) begin
      if (!sram_WEN) mem[sram_A] <= sram_D;
      else           sram_Q <= mem[sram_A];
    end
  end

  typedef struct {
    logic [1:0] req, we;
    logic [3:0] a0, a1;
    logic [7:0] w0, w1;
    logic [1:0] gnt;
    logic       cen, wen;
    logic [3:0] a;
    logic [7:0] d;
    logic [1:0] rv;
    logic       rerr;
    logic [7:0] rd;
  } vec_t;

  vec_t vt [16];

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic vec_t mk(
    input logic [1:0] rq, w, input logic [3:0] a0, a1,
    input logic [7:0] w0, w1, input logic [1:0] g,
    input logic c, wn, input logic [3:0] a,
    input logic [7:0] d, input logic [1:0] rv,
    input logic re, input logic [7:0] rd);
    vec_t v;
    v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1;
    v.w0 = w0; v.w1 = w1; v.gnt = g; v.cen = c;
    v.wen = wn; v.a = a; v.d = d; v.rv = rv;
    v.rerr = re; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rq, w,
                       input logic [3:0] a0, a1,
                       input logic [7:0] w0, w1);
    req = rq; we = w;
    addr = {a1, a0};
    wdata = {rep(w1), rep(w0)};
  endtask

  // Called at a negedge in cycle 0 of a zero-fill
  task automatic do_init(input logic [1:0] rv0,
                         input logic [7:0] rd0,
                         input logic [1:0] g8);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("init%0d cen", i), 128'(sram_CEN), 0);
      chk($sformatf("init%0d wen", i), 128'(sram_WEN), 0);
      chk($sformatf("init%0d a", i), 128'(sram_A), 128'(i));
      chk($sformatf("init%0d d", i), sram_D, 0);
      chk($sformatf("init%0d gnt", i), 128'(gnt), 0);
      chk($sformatf("init%0d done", i), 128'(init_done), 0);
      if (i == 0) begin
        chk("init0 rvalid", 128'(rvalid), 128'(rv0));
        chk("init0 rdata", rdata, rep(rd0));
      end
      @(negedge CLK);
    end
    #1;
    chk("init done", 128'(init_done), 1);
    chk("init end gnt", 128'(gnt), 128'(g8));
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      mem[i] = {4{32'hDEAD_0000 + 32'(i)}};
    sram_Q = {4{32'hBAD0_BAD0}};

    vt[0]  = mk(2'b01,2'b01,3,0,8'hA5,0, 2'b01,0,0,3,8'hA5,0,0,0);
    vt[1]  = mk(2'b10,2'b00,0,3,0,0,     2'b10,0,1,3,0,0,0,0);
    vt[2]  = mk(2'b00,2'b00,0,0,0,0,     2'b00,1,1,0,0,2'b10,0,8'hA5);
    vt[3]  = mk(2'b01,2'b01,1,0,8'h11,0, 2'b01,0,0,1,8'h11,0,0,0);
    vt[4]  = mk(2'b10,2'b10,0,2,0,8'h22, 2'b10,0,0,2,8'h22,0,0,0);
    vt[5]  = mk(2'b11,2'b00,1,2,0,0,     2'b01,0,1,1,0,0,0,0);
    vt[6]  = mk(2'b10,2'b00,1,2,0,0,     2'b10,0,1,2,0,2'b01,0,8'h11);
    vt[7]  = mk(2'b00,2'b00,0,0,0,0,     2'b00,1,1,0,0,2'b10,0,8'h22);
    vt[8]  = mk(2'b10,2'b00,0,9,0,0,     2'b10,1,1,0,0,0,0,0);
    vt[9]  = mk(2'b00,2'b00,0,0,0,0,     2'b00,1,1,0,0,2'b10,1,0);
    vt[10] = mk(2'b01,2'b01,12,0,8'h77,0,2'b01,1,1,0,0,0,0,0);
    vt[11] = mk(2'b01,2'b00,3,0,0,0,     2'b01,0,1,3,0,0,0,0);
    vt[12] = mk(2'b00,2'b00,0,0,0,0,     2'b00,1,1,0,0,2'b01,0,8'hA5);
    vt[13] = mk(2'b11,2'b00,1,2,0,0,     2'b10,0,1,2,0,0,0,0);
    vt[14] = mk(2'b01,2'b00,1,0,0,0,     2'b01,0,1,1,0,2'b10,0,8'h22);
    vt[15] = mk(2'b00,2'b00,0,0,0,0,     2'b00,1,1,0,0,2'b01,0,8'h11);

    reset = 1'b1; clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    chk("rst gnt", 128'(gnt), 0);
    chk("rst rvalid", 128'(rvalid), 0);
    chk("rst rerr", 128'(rerr), 0);
    chk("rst done", 128'(init_done), 0);
    chk("rst rdata", rdata, 0);

    @(negedge CLK);
    reset = 1'b0;
    do_init(2'b00, 8'h00, 2'b00);

    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      drive(vt[i].req, vt[i].we, vt[i].a0, vt[i].a1,
            vt[i].w0, vt[i].w1);
      #1;
      chk($sformatf("v%0d gnt", i), 128'(gnt), 128'(vt[i].gnt));
      chk($sformatf("v%0d cen", i), 128'(sram_CEN), 128'(vt[i].cen));
      chk($sformatf("v%0d wen", i), 128'(sram_WEN), 128'(vt[i].wen));
      chk($sformatf("v%0d a", i), 128'(sram_A), 128'(vt[i].a));
      chk($sformatf("v%0d d", i), sram_D, rep(vt[i].d));
      chk($sformatf("v%0d rvalid", i), 128'(rvalid), 128'(vt[i].rv));
      chk($sformatf("v%0d rerr", i), 128'(rerr), 128'(vt[i].rerr));
      chk($sformatf("v%0d rdata", i), rdata, rep(vt[i].rd));
    end

    // Reset pulse while a read is outstanding
    @(negedge CLK);
    drive(2'b10, 2'b00, 0, 3, 0, 0);
    #1;
    chk("rr gnt", 128'(gnt), 2'b10);
    @(posedge CLK);
    #1;
    chk("rr pending", 128'(rvalid), 2'b10);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rr rvalid", 128'(rvalid), 0);
    chk("rr done", 128'(init_done), 0);
    chk("rr rdata", rdata, 0);
    chk("rr gnt0", 128'(gnt), 0);
    @(negedge CLK);
    reset = 1'b0;
    do_init(2'b00, 8'h00, 2'b00);
    @(negedge CLK);
    drive(2'b01, 2'b00, 3, 0, 0, 0);
    #1;
    chk("rr rd gnt", 128'(gnt), 2'b01);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rr rd rvalid", 128'(rvalid), 2'b01);
    chk("rr rd data", rdata, 0);

    // Fill all words, then clear with core request held
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      drive(2'b01, 2'b01, 4'(i), 0, 8'h30 + 8'(i), 0);
      #1;
      chk($sformatf("fill%0d gnt", i), 128'(gnt), 2'b01);
      chk($sformatf("fill%0d a", i), 128'(sram_A), 128'(i));
    end
    @(negedge CLK);
    drive(2'b10, 2'b00, 0, 5, 0, 0);
    clear = 1'b1;
    #1;
    chk("clr gnt", 128'(gnt), 2'b10);
    chk("clr a", 128'(sram_A), 5);
    @(negedge CLK);
    clear = 1'b0;
    do_init(2'b10, 8'h35, 2'b10);
    chk("clr rd a", 128'(sram_A), 5);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("clr rd rvalid", 128'(rvalid), 2'b10);
    chk("clr rd data", rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
